// File: rtl/audio_i2s_rx_if.sv
// Signal bundle between the WM8978 ADC serial pins / recording control and the I2S receiver.
// slave is the receiver side; master is whatever drives the codec pins and consumes frames.
interface audio_i2s_rx_if #(
    parameter int WL    = 32,
    parameter int CNT_W = 24
);
    logic              aud_lrc;
    logic              aud_adcdat;
    logic              rx_en;
    logic              err_clr;
    logic [2*WL-1:0]   adc_data;
    logic              rx_done;
    logic              slot_err;
    logic [CNT_W-1:0]  frame_cnt;

    modport master (
        output aud_lrc, aud_adcdat, rx_en, err_clr,
        input  adc_data, rx_done, slot_err, frame_cnt
    );

    modport slave (
        input  aud_lrc, aud_adcdat, rx_en, err_clr,
        output adc_data, rx_done, slot_err, frame_cnt
    );
endinterface

// File: rtl/audio_i2s_rx.sv
// Stereo I2S receiver clocked by the codec bit clock: deserialises left/right slots,
// pairs them into frames with a one-cycle rx_done strobe, flags short slots, counts frames.
module audio_i2s_rx #(
    parameter int WL    = 32,
    parameter int CNT_W = 24
) (
    input  logic          aud_bclk,
    input  logic          rst_n,
    audio_i2s_rx_if.slave bus
);
    localparam int BW = $clog2(WL + 1);
    localparam logic [BW-1:0]    WL_CNT    = WL[BW-1:0];
    localparam logic [BW-1:0]    CNT_ONE   = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] FRAME_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    state_t            state_reg, state_next;
    logic              lrc_d_reg;
    logic              ch_reg;
    logic              slot_act_reg;
    logic [BW-1:0]     bit_cnt_reg;
    logic [WL-1:0]     shift_reg;
    logic [WL-1:0]     left_hold_reg;
    logic [WL-1:0]     right_hold_reg;
    logic              left_ok_reg, left_ok_next;
    logic              frame_pend_reg, frame_pend_next;
    logic              left_cap;
    logic [2*WL-1:0]   adc_data_reg;
    logic              rx_done_reg;
    logic              slot_err_reg;
    logic [CNT_W-1:0]  frame_cnt_reg;

    logic              lrc_edge;
    logic              left_start;
    logic              shifting;
    logic              full_done;
    logic              short_done;
    logic              word_done;
    logic [WL-1:0]     word;

    // slot_act keeps bits arriving before the first slot boundary after reset out of the shifter
    always_comb begin
        lrc_edge   = bus.aud_lrc ^ lrc_d_reg;
        left_start = lrc_edge & ~bus.aud_lrc;
        shifting   = slot_act_reg & ~lrc_edge & (bit_cnt_reg < WL_CNT);
        full_done  = shifting & (bit_cnt_reg == WL_CNT - CNT_ONE);
        short_done = slot_act_reg & lrc_edge & (bit_cnt_reg != '0) & (bit_cnt_reg < WL_CNT);
        word_done  = full_done | short_done;
        if (full_done) begin
            word = {shift_reg[WL-2:0], bus.aud_adcdat};
        end else begin
            // short slot: received bits sit in the LSBs, move them to the top, zero-fill below
            word = shift_reg << (WL_CNT - bit_cnt_reg);
        end
    end

    always_ff @(posedge aud_bclk or negedge rst_n) begin
        if (!rst_n) begin
            lrc_d_reg    <= 1'b0;
            ch_reg       <= 1'b0;
            slot_act_reg <= 1'b0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
        end else begin
            lrc_d_reg <= bus.aud_lrc;
            if (lrc_edge) begin
                slot_act_reg <= 1'b1;
                ch_reg       <= bus.aud_lrc;
                bit_cnt_reg  <= '0;
            end else if (shifting) begin
                shift_reg   <= {shift_reg[WL-2:0], bus.aud_adcdat};
                bit_cnt_reg <= bit_cnt_reg + CNT_ONE;
            end
        end
    end

    // Completion is acted on in the same edge it happens, so a short right slot ending on a
    // left-slot boundary still produces its frame instead of being dropped by the restart.
    always_comb begin
        state_next      = state_reg;
        left_ok_next    = left_ok_reg;
        frame_pend_next = 1'b0;
        left_cap        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (left_start) begin
                    state_next = LEFT;
                end
            end
            LEFT: begin
                if (word_done && !ch_reg) begin
                    left_cap     = 1'b1;
                    left_ok_next = 1'b1;
                    state_next   = RIGHT;
                end
            end
            RIGHT: begin
                if (word_done && ch_reg) begin
                    frame_pend_next = left_ok_reg;
                    left_ok_next    = 1'b0;
                    state_next      = LEFT;
                end else if (left_start) begin
                    left_ok_next = 1'b0;
                    state_next   = LEFT;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (!bus.rx_en) begin
            state_next      = IDLE;
            left_ok_next    = 1'b0;
            frame_pend_next = 1'b0;
            left_cap        = 1'b0;
        end
    end

    always_ff @(posedge aud_bclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            left_ok_reg    <= 1'b0;
            frame_pend_reg <= 1'b0;
            left_hold_reg  <= '0;
            right_hold_reg <= '0;
            adc_data_reg   <= '0;
            rx_done_reg    <= 1'b0;
            frame_cnt_reg  <= '0;
            slot_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            left_ok_reg    <= left_ok_next;
            frame_pend_reg <= frame_pend_next;
            if (left_cap) begin
                left_hold_reg <= word;
            end
            if (frame_pend_next) begin
                right_hold_reg <= word;
            end
            // the strobe edge re-checks rx_en so a disable landing on it suppresses the frame
            rx_done_reg <= frame_pend_reg & bus.rx_en;
            if (frame_pend_reg && bus.rx_en) begin
                adc_data_reg <= {left_hold_reg, right_hold_reg};
                if (frame_cnt_reg != '1) begin
                    frame_cnt_reg <= frame_cnt_reg + FRAME_ONE;
                end
            end
            if (short_done) begin
                slot_err_reg <= 1'b1;
            end else if (bus.err_clr) begin
                slot_err_reg <= 1'b0;
            end
        end
    end

    assign bus.adc_data  = adc_data_reg;
    assign bus.rx_done   = rx_done_reg;
    assign bus.slot_err  = slot_err_reg;
    assign bus.frame_cnt = frame_cnt_reg;
endmodule
